// File: rtl/arp_pkg.sv
`default_nettype none
// ============================================================================
// arp_pkg : ARP request field constants and FSM state encoding
// Revision: 1.0
// ============================================================================
package arp_pkg;

    localparam logic [15:0] ARP_ETHERTYPE = 16'h0806;
    localparam logic [15:0] HTYPE_ETH     = 16'h0001;
    localparam logic [15:0] PTYPE_IP      = 16'h0800;
    localparam logic [15:0] OPER_REQUEST  = 16'h0001;
    localparam int          ARP_HDR_BYTES = 42;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } arp_state_t;

endpackage
`default_nettype wire

// File: rtl/arp_req_byte_mux.sv
`default_nettype none
// ============================================================================
// arp_req_byte_mux : selects the ARP request byte at a given frame offset
// Revision: 1.0
// ============================================================================
module arp_req_byte_mux
    import arp_pkg::*;
(
    input  logic [6:0]  byte_cnt,
    input  logic [47:0] frm_mac,
    input  logic [31:0] frm_lip,
    input  logic [31:0] frm_tip,
    output logic [7:0]  byte_out
);

    always_comb begin
        byte_out = 8'h00;
        case (byte_cnt)
            7'd0, 7'd1, 7'd2, 7'd3, 7'd4, 7'd5: byte_out = 8'hFF;
            7'd6:  byte_out = frm_mac[47:40];
            7'd7:  byte_out = frm_mac[39:32];
            7'd8:  byte_out = frm_mac[31:24];
            7'd9:  byte_out = frm_mac[23:16];
            7'd10: byte_out = frm_mac[15:8];
            7'd11: byte_out = frm_mac[7:0];
            7'd12: byte_out = ARP_ETHERTYPE[15:8];
            7'd13: byte_out = ARP_ETHERTYPE[7:0];
            7'd14: byte_out = HTYPE_ETH[15:8];
            7'd15: byte_out = HTYPE_ETH[7:0];
            7'd16: byte_out = PTYPE_IP[15:8];
            7'd17: byte_out = PTYPE_IP[7:0];
            7'd18: byte_out = 8'h06;
            7'd19: byte_out = 8'h04;
            7'd20: byte_out = OPER_REQUEST[15:8];
            7'd21: byte_out = OPER_REQUEST[7:0];
            7'd22: byte_out = frm_mac[47:40];
            7'd23: byte_out = frm_mac[39:32];
            7'd24: byte_out = frm_mac[31:24];
            7'd25: byte_out = frm_mac[23:16];
            7'd26: byte_out = frm_mac[15:8];
            7'd27: byte_out = frm_mac[7:0];
            7'd28: byte_out = frm_lip[31:24];
            7'd29: byte_out = frm_lip[23:16];
            7'd30: byte_out = frm_lip[15:8];
            7'd31: byte_out = frm_lip[7:0];
            7'd38: byte_out = frm_tip[31:24];
            7'd39: byte_out = frm_tip[23:16];
            7'd40: byte_out = frm_tip[15:8];
            7'd41: byte_out = frm_tip[7:0];
            // target MAC (32..37) and trailing pad are zero
            default: byte_out = 8'h00;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/arp_request_gen.sv
`default_nettype none
// ============================================================================
// arp_request_gen : buffers missed-lookup requests and streams ARP requests
// Revision: 1.0
// ============================================================================
module arp_request_gen
    import arp_pkg::*;
#(
    parameter int FRAME_BYTES = 60,
    parameter int DROP_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       req_ip,
    input  logic [23:0]       req_netport,
    input  logic              req_en,
    input  logic [47:0]       local_mac,
    input  logic [31:0]       local_ip,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              tx_sof,
    output logic              tx_eof,
    output logic [23:0]       tx_netport,
    output logic              busy,
    output logic [DROP_W-1:0] drop_cnt
);

    localparam logic [6:0] LAST_BYTE = 7'(FRAME_BYTES - 1);

    arp_state_t        r_state;
    arp_state_t        w_state_nxt;
    logic              r_pend_valid;
    logic [31:0]       r_pend_ip;
    logic [23:0]       r_pend_netport;
    logic [31:0]       r_frm_ip;
    logic [23:0]       r_frm_netport;
    logic [47:0]       r_frm_mac;
    logic [31:0]       r_frm_lip;
    logic [6:0]        r_byte_cnt;
    logic              r_busy;
    logic [DROP_W-1:0] r_drop_cnt;

    logic              w_send;
    logic              w_accept;
    logic              w_last;
    logic              w_load;
    logic              w_dup;
    logic              w_capture;
    logic              w_drop;
    logic [7:0]        w_mux_byte;

    assign w_send   = (r_state == ST_SEND);
    assign w_accept = w_send && tx_ready;
    assign w_last   = (r_byte_cnt == LAST_BYTE);
    assign w_load   = (r_state == ST_IDLE) && r_pend_valid;

    // The pending slot counts as free on the edge its entry moves into the frame registers
    assign w_dup     = req_en && ((r_pend_valid && (req_ip == r_pend_ip)) ||
                                  (w_send && (req_ip == r_frm_ip)));
    assign w_capture = req_en && !w_dup && (!r_pend_valid || w_load);
    assign w_drop    = req_en && !w_dup && r_pend_valid && !w_load;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (r_pend_valid) w_state_nxt = ST_SEND;
            ST_SEND: if (w_accept && w_last) w_state_nxt = ST_GAP;
            ST_GAP:  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_pend_valid   <= 1'b0;
            r_pend_ip      <= '0;
            r_pend_netport <= '0;
            r_frm_ip       <= '0;
            r_frm_netport  <= '0;
            r_frm_mac      <= '0;
            r_frm_lip      <= '0;
            r_byte_cnt     <= '0;
            r_busy         <= 1'b0;
            r_drop_cnt     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= r_pend_valid || (r_state != ST_IDLE);

            if (w_load) begin
                r_frm_ip      <= r_pend_ip;
                r_frm_netport <= r_pend_netport;
                r_frm_mac     <= local_mac;
                r_frm_lip     <= local_ip;
                r_byte_cnt    <= '0;
            end else if (w_accept) begin
                r_byte_cnt <= w_last ? 7'd0 : r_byte_cnt + 7'd1;
            end

            if (w_capture) begin
                r_pend_valid   <= 1'b1;
                r_pend_ip      <= req_ip;
                r_pend_netport <= req_netport;
            end else if (w_load) begin
                r_pend_valid <= 1'b0;
            end

            if (w_drop && !(&r_drop_cnt)) begin
                r_drop_cnt <= r_drop_cnt + 1'b1;
            end
        end
    end

    arp_req_byte_mux u_byte_mux (
        .byte_cnt (r_byte_cnt),
        .frm_mac  (r_frm_mac),
        .frm_lip  (r_frm_lip),
        .frm_tip  (r_frm_ip),
        .byte_out (w_mux_byte)
    );

    assign tx_valid   = w_send;
    assign tx_data    = w_send ? w_mux_byte : 8'h00;
    assign tx_sof     = w_send && (r_byte_cnt == 7'd0);
    assign tx_eof     = w_send && w_last;
    assign tx_netport = r_frm_netport;
    assign busy       = r_busy;
    assign drop_cnt   = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_arp_request_gen.sv
`default_nettype none
// ============================================================================
// tb_arp_request_gen : scoreboarded bench with a transaction-level ARP model
// Revision: 1.0
// ============================================================================
module tb_arp_request_gen;

    localparam int FB = 60;
    localparam int DW = 16;
    localparam logic [DW-1:0] SAT = '1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [31:0]   req_ip = '0;
    logic [23:0]   req_netport = '0;
    logic          req_en = 1'b0;
    logic [47:0]   local_mac = 48'h000A35010203;
    logic [31:0]   local_ip = 32'hC0A80001;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready = 1'b1;
    logic          tx_sof;
    logic          tx_eof;
    logic [23:0]   tx_netport;
    logic          busy;
    logic [DW-1:0] drop_cnt;

    always #5 clk = ~clk;

    arp_request_gen #(.FRAME_BYTES(FB), .DROP_W(DW)) dut (
        .clk(clk), .rst(rst), .req_ip(req_ip), .req_netport(req_netport),
        .req_en(req_en), .local_mac(local_mac), .local_ip(local_ip),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .tx_sof(tx_sof), .tx_eof(tx_eof), .tx_netport(tx_netport),
        .busy(busy), .drop_cnt(drop_cnt)
    );

    typedef struct {
        logic [31:0] ip;
        logic [23:0] np;
        logic [47:0] mac;
        logic [31:0] lip;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Expected wire byte at offset i, straight from the ARP request layout
    function automatic logic [7:0] exp_byte(input int i, input exp_t e);
        if (i < 6)  return 8'hFF;
        if (i < 12) return e.mac[8*(11-i) +: 8];
        case (i)
            12: return 8'h08;  13: return 8'h06;
            14: return 8'h00;  15: return 8'h01;
            16: return 8'h08;  17: return 8'h00;
            18: return 8'h06;  19: return 8'h04;
            20: return 8'h00;  21: return 8'h01;
            default: ;
        endcase
        if (i >= 22 && i < 28) return e.mac[8*(27-i) +: 8];
        if (i >= 28 && i < 32) return e.lip[8*(31-i) +: 8];
        if (i >= 38 && i < 42) return e.ip[8*(41-i) +: 8];
        return 8'h00;
    endfunction

    // ---------------- monitor ----------------
    int mon_idx = 0;
    bit in_frame = 0;
    int frames_done = 0;
    int sof_cyc = 0, prev_sof_cyc = 0;
    int eof_cyc = -100;

    always @(negedge clk) begin
        if (rst) begin
            mon_idx  = 0;
            in_frame = 0;
        end else if (tx_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_frame", 64'(exp_q.size()), 64'd1);
            end else begin
                if (!in_frame) begin
                    in_frame     = 1;
                    prev_sof_cyc = sof_cyc;
                    sof_cyc      = cyc;
                    check("interframe_idle", 64'(cyc - eof_cyc >= 2), 64'd1);
                end
                check($sformatf("frame_byte%0d", mon_idx),
                      64'({tx_data, tx_sof, tx_eof, tx_netport}),
                      64'({exp_byte(mon_idx, exp_q[0]), mon_idx == 0, mon_idx == FB-1, exp_q[0].np}));
                if (tx_ready) begin
                    if (mon_idx == FB-1) begin
                        void'(exp_q.pop_front());
                        frames_done++;
                        eof_cyc  = cyc;
                        mon_idx  = 0;
                        in_frame = 0;
                    end else begin
                        mon_idx++;
                    end
                end
            end
        end
    end

    // ---------------- reference model ----------------
    bit          m_pend_v = 0;
    logic [31:0] m_pend_ip;
    logic [23:0] m_pend_np;
    int          m_phase = 0;      // 0 idle, 1 transmitting, 2 inter-frame gap
    int          m_beats = 0;
    logic [31:0] m_fly_ip;
    int          m_drops = 0;

    task automatic model_edge(input logic en, input logic [31:0] ip, input logic [23:0] np,
                              input logic rdy);
        bit loading, take;
        loading = (m_phase == 0) && m_pend_v;
        take    = 0;
        if (en) begin
            if ((m_pend_v && ip == m_pend_ip) || (m_phase == 1 && ip == m_fly_ip)) take = 0;
            else if (!m_pend_v || loading) take = 1;
            else if (m_drops < 2**DW - 1) m_drops++;
        end
        if (m_phase == 1) begin
            if (rdy) begin
                m_beats++;
                if (m_beats == FB) m_phase = 2;
            end
        end else if (m_phase == 2) begin
            m_phase = 0;
        end else if (loading) begin
            m_phase  = 1;
            m_beats  = 0;
            m_fly_ip = m_pend_ip;
            m_pend_v = 0;
        end
        if (take) begin
            m_pend_v  = 1;
            m_pend_ip = ip;
            m_pend_np = np;
            exp_q.push_back('{ip: ip, np: np, mac: local_mac, lip: local_ip});
        end
    endtask

    task automatic step(input logic en, input logic [31:0] ip, input logic [23:0] np,
                        input logic rdy);
        @(posedge clk); #1;
        req_en = en; req_ip = ip; req_netport = np; tx_ready = rdy;
        model_edge(en, ip, np, rdy);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, 24'h0, 1'b1);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; req_en = 1'b0;
        m_pend_v = 0; m_phase = 0; m_beats = 0; m_drops = 0;
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        check("rst_tx_valid", 64'(tx_valid), 64'd0);
        check("rst_tx_data", 64'(tx_data), 64'd0);
        check("rst_sof_eof", 64'({tx_sof, tx_eof}), 64'd0);
        check("rst_netport", 64'(tx_netport), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_drop_cnt", 64'(drop_cnt), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int c0, f0, guard;
        bit rdy;

        do_reset();

        // single request, ready always high
        f0 = frames_done;
        step(1'b1, 32'hC0A8000A, 24'h123456, 1'b1);
        c0 = cyc;
        idle(FB + 10);
        check("single_frames", 64'(frames_done - f0), 64'd1);
        check("single_latency", 64'(sof_cyc - c0), 64'd2);
        check("single_span", 64'(eof_cyc - sof_cyc + 1), 64'(FB));
        check("single_busy_end", 64'(busy), 64'd0);

        // backpressure: ready alternates, high on the first valid cycle
        f0 = frames_done;
        step(1'b1, 32'hC0A8000B, 24'hABCDEF, 1'b1);
        c0 = cyc;
        for (int i = 1; i < 2*FB + 10; i++) step(1'b0, 32'h0, 24'h0, (i % 2) == 0);
        idle(5);
        check("bp_frames", 64'(frames_done - f0), 64'd1);
        check("bp_span", 64'(eof_cyc - sof_cyc + 1), 64'(2*FB - 1));

        // burst of three distinct IPs
        f0 = frames_done;
        step(1'b1, 32'h0A000001, 24'h000001, 1'b1);
        step(1'b1, 32'h0A000002, 24'h000002, 1'b1);
        step(1'b1, 32'h0A000003, 24'h000003, 1'b1);
        idle(2*FB + 10);
        check("burst_frames", 64'(frames_done - f0), 64'd2);
        check("burst_drop_cnt", 64'(drop_cnt), 64'd1);
        check("burst_spacing", 64'(sof_cyc - prev_sof_cyc), 64'(FB + 2));

        // duplicates while in flight and while pending
        f0 = frames_done;
        step(1'b1, 32'h0B000001, 24'h0000B1, 1'b1);
        idle(4);
        step(1'b1, 32'h0B000001, 24'h0000B1, 1'b1);
        step(1'b1, 32'h0B000002, 24'h0000B2, 1'b0);
        step(1'b1, 32'h0B000002, 24'h0000B2, 1'b0);
        step(1'b1, 32'h0B000001, 24'h0000B1, 1'b0);
        step(1'b1, 32'h0B000002, 24'h0000B2, 1'b1);
        idle(2*FB + 10);
        check("dup_frames", 64'(frames_done - f0), 64'd2);
        check("dup_drop_cnt", 64'(drop_cnt), 64'd1);

        // reset in the middle of a frame
        step(1'b1, 32'h0C000001, 24'h0000C1, 1'b1);
        guard = 0;
        while (mon_idx != 20 && guard < 200) begin
            step(1'b0, 32'h0, 24'h0, 1'b1);
            guard++;
        end
        check("reach_byte20", 64'(guard < 200), 64'd1);
        do_reset();
        f0 = frames_done;
        step(1'b1, 32'h0C000002, 24'h0000C2, 1'b1);
        idle(FB + 10);
        check("post_reset_frames", 64'(frames_done - f0), 64'd1);

        // randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            rdy = ($urandom % 4) != 0;
            step(($urandom % 3) == 0, 32'hC0A80064 + ($urandom % 5), 24'($urandom), rdy);
        end
        idle(2*FB + 20);
        check("rand_drop_cnt", 64'(drop_cnt), 64'(m_drops));
        check("rand_sb_empty", 64'(exp_q.size()), 64'd0);
        check("rand_busy_end", 64'(busy), 64'd0);

        // drop counter saturation
        do_reset();
        step(1'b1, 32'hC0A800C8, 24'h0000D1, 1'b0);
        step(1'b1, 32'hC0A800C9, 24'h0000D2, 1'b0);
        for (int i = 0; i < 2**DW + 5; i++) step(1'b1, 32'h0D000000 + i, 24'h0, 1'b0);
        step(1'b0, 32'h0, 24'h0, 1'b1);
        @(negedge clk);
        check("sat_drop_cnt", 64'(drop_cnt), 64'(SAT));
        check("sat_model", 64'(drop_cnt), 64'(m_drops));
        f0 = frames_done;
        idle(2*FB + 10);
        check("sat_frames", 64'(frames_done - f0), 64'd2);
        check("sat_hold", 64'(drop_cnt), 64'(SAT));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
